// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller: light heads, FSM states
// and default timing/width parameters.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_GREEN  = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_RED    = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_HG   = 3'd1,
        ST_HY   = 3'd2,
        ST_FG   = 3'd3,
        ST_FY   = 3'd4
    } state_t;

    localparam int unsigned BLANK_DEFAULT = 2;
    localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Timer handshake between the light controller (master) and the interval
// timer (slave): start pulse out, short/long timeout flags back.
interface traffic_light_ctrl_if;

    logic st;
    logic ts;
    logic tl;

    modport master (output st, input ts, input tl);
    modport slave  (input st, output ts, output tl);

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a level input asynchronous to clk; resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road light controller: drives both heads, pulses the timer
// start, blanks timer artefacts after each start and counts farm grants.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned BLANK = BLANK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 c,
    traffic_light_ctrl_if.master tmr,
    output logic [1:0]           hl,
    output logic [1:0]           fl,
    output logic [CNT_W-1:0]     grant_cnt
);

    localparam int unsigned          BLANK_W    = $clog2(BLANK + 2);
    localparam logic [BLANK_W-1:0]   BLANK_LOAD = BLANK_W'(BLANK);

    state_t             r_state;
    state_t             w_next;
    light_t             r_hl;
    light_t             r_fl;
    light_t             w_hl;
    light_t             w_fl;
    logic               r_st;
    logic               w_st;
    logic [BLANK_W-1:0] r_blank;
    logic [CNT_W-1:0]   r_grant;
    logic               w_grant_inc;
    logic               w_c_s;
    logic               w_quiet;
    logic               w_ts_q;
    logic               w_tl_q;

    sync2 u_sync_c (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (c),
        .o_q   (w_c_s)
    );

    // The blank counter loads from st, so the st cycle itself is also held
    // quiet; this keeps st from ever firing on consecutive cycles.
    assign w_quiet = ~r_st & (r_blank == '0);
    assign w_ts_q  = tmr.ts & w_quiet;
    assign w_tl_q  = tmr.tl & w_quiet;

    always_comb begin
        w_next      = r_state;
        w_grant_inc = 1'b0;
        case (r_state)
            ST_INIT: w_next = ST_HG;
            ST_HG:   if (w_c_s & w_tl_q) w_next = ST_HY;
            ST_HY: begin
                if (w_ts_q) begin
                    w_next      = ST_FG;
                    w_grant_inc = 1'b1;
                end
            end
            ST_FG:   if (w_quiet & (~w_c_s | w_tl_q)) w_next = ST_FY;
            ST_FY:   if (w_ts_q) w_next = ST_HG;
            default: w_next = ST_INIT;
        endcase

        w_st = (w_next != r_state) && (w_next != ST_INIT);

        w_hl = LIGHT_RED;
        w_fl = LIGHT_RED;
        case (w_next)
            ST_HG:   w_hl = LIGHT_GREEN;
            ST_HY:   w_hl = LIGHT_YELLOW;
            ST_FG:   w_fl = LIGHT_GREEN;
            ST_FY:   w_fl = LIGHT_YELLOW;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_st    <= 1'b0;
            r_hl    <= LIGHT_RED;
            r_fl    <= LIGHT_RED;
        end else begin
            r_state <= w_next;
            r_st    <= w_st;
            r_hl    <= w_hl;
            r_fl    <= w_fl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if (r_st) begin
            r_blank <= BLANK_LOAD;
        end else if (r_blank != '0) begin
            r_blank <= r_blank - BLANK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
        end else if (w_grant_inc && (r_grant != '1)) begin
            r_grant <= r_grant + CNT_W'(1);
        end
    end

    assign tmr.st    = r_st;
    assign hl        = r_hl;
    assign fl        = r_fl;
    assign grant_cnt = r_grant;

endmodule
